mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers for the harvard MIPS core. It sits directly downstream of the ALU-control decode: the decoder issues MULT, MULTU, DIV, DIVU, MTHI and MTLO here instead of to the combinational ALU. Multiply and divide run as multi-cycle operations, and `busy` stalls the core. HI and LO are exported for MFHI/MFLO writeback.

Parameters:
XLEN, 32, operand width; iteration count equals XLEN.
DIV0_QUOT, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
clk_enable  input  1  global stall; when low, all state is held
start  input  1  issue strobe for the operation on `op`
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
rs_val  input  XLEN  rs operand (multiplicand / dividend / MT source)
rt_val  input  XLEN  rt operand (multiplier / divisor)
busy  output  1  high while a mult/div is in progress
done  output  1  one-cycle pulse when HI/LO hold a new mult/div result
hi  output  XLEN  HI register
lo  output  XLEN  LO register

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state = IDLE
  - hi = 0, lo = 0
  - busy = 0, done = 0
  - internal counter and accumulators = 0
- Reset asserted mid-operation aborts the operation, with the same values as above.
- clk_enable low: no register changes, including the state, the counter and the done pulse (done stays at its current level).
- All updates below are on the rising edge of clk with clk_enable = 1.
- Accept rule: start is accepted only when state = IDLE. start while busy = 1 is ignored; upstream holds the instruction on busy.
- States: IDLE, RUN, FIX.
  - IDLE, start, op in {MULT, MULTU, DIV, DIVU}:
    - latch operand magnitudes; signed ops take the two's-complement absolute value
    - latch result-sign flags and the divide-by-zero flag (rt_val = 0, div ops only)
    - count = 0, go to RUN.
  - IDLE, start, MTHI: hi <= rs_val next edge. MTLO: lo <= rs_val. No busy, no done, stay in IDLE.
  - IDLE, start, illegal op: ignored.
  - RUN: one iteration per edge, count increments. After XLEN iterations (count = XLEN-1 on that edge), go to FIX.
    - Multiply: shift-add on a 2*XLEN product register.
    - Divide: restoring divide, one quotient bit per iteration.
  - FIX: apply sign correction, write hi/lo, set done = 1 (registered, visible the next cycle), go to IDLE.
- busy = (state != IDLE), a registered decode of the state.
- Latency:
  - Accept edge is edge 0.
  - RUN occupies edges 1..XLEN; FIX is edge XLEN+1.
  - New hi/lo and done = 1 are visible after edge XLEN+1 (34 cycles for XLEN = 32).
  - done falls after the next enabled edge.
- A new start may be accepted in the cycle where done = 1 (state is already IDLE).
- Multiply results:
  - {hi, lo} = full 2*XLEN product.
  - Signed: product negated if the sign bits of rs_val and rt_val differ.
- Divide results:
  - lo = quotient truncated toward zero, hi = remainder.
  - Signed: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Signed INT_MIN / -1: lo = 32'h80000000, hi = 0 (natural XLEN-bit wrap, no trap).
  - Divide-by-zero, signed or unsigned: full latency, lo = DIV0_QUOT, hi = rs_val (raw dividend).
- Operand inputs are sampled only at the accept edge; later changes have no effect.
- MTHI/MTLO are never presented while busy (upstream stall). If one is presented, it is ignored like any other start while busy.

Test Plan:
- MULTU, rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> busy for 34 cycles, then done pulse, hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT, rs=-3, rt=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Then DIV, rs=-7, rt=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Then DIV, rs=32'h80000000, rt=-1 -> lo=32'h80000000, hi=0.
- DIVU, rs=100, rt=0 -> lo=32'hFFFFFFFF, hi=32'h00000064, done after 34 cycles. Also DIVU 100/7 -> lo=14, hi=2.
- MTHI, rs=32'hDEADBEEF, then MTLO, rs=32'h12345678 -> hi and lo update one edge each; busy and done stay 0.
- Start MULTU 6*7; assert start with DIVU 1/1 at cycle 10 -> second start ignored, result lo=42, hi=0. Hold clk_enable low for 5 cycles mid-RUN -> done delayed by exactly 5 cycles.
- Start DIV; assert reset at cycle 15 -> busy=0, done=0, hi=lo=0 immediately (asynchronous); a subsequent MULTU 2*3 gives lo=6.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Multiply is a radix-2 shift-add over XLEN iterations.
// Divide is a restoring divide producing one quotient bit per iteration.
// Signed operations run on operand magnitudes; signs are fixed up in a
// final FIX state. MTHI/MTLO write HI/LO directly from IDLE.
module mips_muldiv_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int              PW     = 2 * XLEN;
    localparam int              CNT_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negation of an XLEN-bit value when en is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? ((~v) + XLEN'(1)) : v;
    endfunction

    // Two's-complement negation of a full-width product when en is set.
    function automatic logic [PW-1:0] cond_neg_wide(input logic [PW-1:0] v, input logic en);
        return en ? ((~v) + PW'(1)) : v;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PW-1:0]     acc_q,   acc_d;     // product, or {remainder, quotient}
    logic [XLEN-1:0]   opnd_q,  opnd_d;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]   dvd_q,   dvd_d;     // raw dividend, returned in HI on divide-by-zero
    logic              is_div_q,  is_div_d;
    logic              neg_q,     neg_d;   // negate product / quotient
    logic              rem_neg_q, rem_neg_d;
    logic              div0_q,    div0_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand preparation at the accept edge: signed ops use magnitudes.
    logic              op_signed;
    logic              rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_mag, rt_mag;

    assign op_signed = ~op[0];
    assign rs_neg    = op_signed & rs_val[XLEN-1];
    assign rt_neg    = op_signed & rt_val[XLEN-1];
    assign rs_mag    = cond_neg(rs_val, rs_neg);
    assign rt_mag    = cond_neg(rt_val, rt_neg);

    // One multiply step: conditionally add multiplicand into the high half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [PW-1:0]     mul_next;

    assign mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring-divide step: shift in the next dividend bit and try a subtract.
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [PW-1:0]     div_next;

    assign div_shift = acc_q[PW-1:XLEN-1];
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign-corrected results presented to HI/LO in the FIX state.
    logic [PW-1:0]     prod_fixed;
    logic [XLEN-1:0]   quot_fixed, rem_fixed;

    assign prod_fixed = cond_neg_wide(acc_q, neg_q);
    assign quot_fixed = cond_neg(acc_q[XLEN-1:0], neg_q);
    assign rem_fixed  = cond_neg(acc_q[PW-1:XLEN], rem_neg_q);

    // Next-state and datapath control for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d     = {{XLEN{1'b0}}, rs_mag};
                            opnd_d    = rt_mag;
                            dvd_d     = rs_val;
                            is_div_d  = op[1];
                            neg_d     = rs_neg ^ rt_neg;
                            rem_neg_d = rs_neg;
                            div0_d    = op[1] & (rt_val == {XLEN{1'b0}});
                            count_d   = {CNT_W{1'b0}};
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fixed[PW-1:XLEN];
                    lo_d = prod_fixed[XLEN-1:0];
                end else if (div0_q) begin
                    hi_d = dvd_q;
                    lo_d = DIV0_QUOT;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_FIX);
    end

    // State and datapath registers; everything holds while clk_enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= {CNT_W{1'b0}};
            acc_q     <= {PW{1'b0}};
            opnd_q    <= {XLEN{1'b0}};
            dvd_q     <= {XLEN{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO and completion cycle
// are queued at issue and checked when done rises.
module tb_mips_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mips_muldiv_unit #(.XLEN(32), .DIV0_QUOT(32'hFFFFFFFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hilo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} for a mult/div operation.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int     sa, sbv, q, r;
        logic [63:0] res;
        res = 64'd0;
        case (o)
            OP_MULTU: res = 64'(a) * 64'(b);
            OP_MULT: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                res = sp;
            end
            OP_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'd0, 32'h80000000};
                else begin
                    sa  = a;
                    sbv = b;
                    q   = sa / sbv;
                    r   = sa % sbv;
                    res = {r, q};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Called at a negedge; the following posedge is the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input int extra);
        exp_t e;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (push) begin
            e.hilo = model(o, a, b);
            e.cyc  = cyc + 34 + extra;
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        rs_val = ~a;
        rt_val = ~b;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    // Result monitor: compares on each rising edge of done.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hilo", {hi, lo}, mon_e.hilo);
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        done_prev <= done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_idle();

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 0);
        wait_idle();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 0);
        wait_idle();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        wait_idle();
        issue(OP_DIVU, 32'd100, 32'd0, 1, 0);
        wait_idle();
        issue(OP_DIVU, 32'd100, 32'd7, 1, 0);
        wait_idle();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0, 1, 0);
        wait_idle();
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, 0);
        wait_idle();
        issue(OP_MULT, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        wait_idle();

        issue(OP_MTHI, 32'hDEADBEEF, 32'd0, 0, 0);
        check("mthi_hi", 64'(hi), 64'hDEADBEEF);
        check("mthi_busy_done", {busy, done}, 64'd0);
        issue(OP_MTLO, 32'h12345678, 32'd0, 0, 0);
        check("mtlo_hilo", {hi, lo}, 64'hDEADBEEF_12345678);
        check("mtlo_busy_done", {busy, done}, 64'd0);
        issue(OP_ILL, 32'h11111111, 32'h22222222, 0, 0);
        @(negedge clk);
        check("illegal_hilo", {hi, lo}, 64'hDEADBEEF_12345678);
        check("illegal_busy", 64'(busy), 64'd0);

        // Second start while busy is ignored; a 5-cycle stall delays completion.
        issue(OP_MULTU, 32'd6, 32'd7, 1, 5);
        repeat (8) @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs_val = 32'd1; rt_val = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_stall", 64'(busy), 64'd1);
        clk_enable = 1'b1;
        wait_idle();

        // Random mix, each new op issued in the cycle done is high.
        issue(OP_MULTU, 32'd12345, 32'd678, 1, 0);
        for (int i = 0; i < 8; i++) begin
            o = 3'(i % 4);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            for (int k = 0; k < 100 && !done; k++) @(negedge clk);
            check("done_seen", 64'(done), 64'd1);
            issue(o, a, b, 1, 0);
        end
        wait_idle();

        // Asynchronous reset aborts an operation in progress.
        issue(OP_MTHI, 32'hCAFEF00D, 32'd0, 0, 0);
        issue(OP_DIV, 32'd1000, 32'd3, 0, 0);
        repeat (13) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("areset_busy_done", {busy, done}, 64'd0);
        check("areset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        issue(OP_MULTU, 32'd2, 32'd3, 1, 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
